// File: rtl/cache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cache_pkg                                                    |
// | Description : Shared line/select types, FSM states and byte-merge helper.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package cache_pkg;

    localparam int LINE_BYTES = 16;

    typedef logic [8*LINE_BYTES-1:0] cache_line_t;
    typedef logic [LINE_BYTES-1:0]   line_sel_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_t;

    function automatic cache_line_t merge_line(
        input cache_line_t old_line,
        input cache_line_t new_line,
        input line_sel_t   sel
    );
        cache_line_t res;
        res = old_line;
        for (int i = 0; i < LINE_BYTES; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = new_line[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_plru.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cache_plru                                                   |
// | Description : Tree pseudo-LRU update and victim selection (combinational). |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module cache_plru
    import cache_pkg::*;
#(
    parameter int WAYS = 2
) (
    input  logic [WAYS-2:0]         i_tree,
    input  logic [$clog2(WAYS)-1:0] i_hit_way,
    output logic [WAYS-2:0]         o_tree,
    output logic [$clog2(WAYS)-1:0] o_victim
);

    localparam int c_LEVELS = $clog2(WAYS);

    // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right);
    // a node bit of 1 means the victim lies in the right subtree.
    always_comb begin : p_update
        int   w_node;
        logic w_dir;
        o_tree = i_tree;
        w_node = 0;
        w_dir  = 1'b0;
        for (int l = 0; l < c_LEVELS; l++) begin
            w_dir = i_hit_way[c_LEVELS-1-l];
            o_tree[c_LEVELS'(w_node)] = ~w_dir;
            w_node = 2*w_node + 1 + int'(w_dir);
        end
    end

    always_comb begin : p_victim
        int   w_node;
        logic w_dir;
        o_victim = '0;
        w_node   = 0;
        w_dir    = 1'b0;
        for (int l = 0; l < c_LEVELS; l++) begin
            w_dir = i_tree[c_LEVELS'(w_node)];
            o_victim[c_LEVELS-1-l] = w_dir;
            w_node = 2*w_node + 1 + int'(w_dir);
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_nway.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cache_nway                                                   |
// | Description : N-way set-associative write-back/write-allocate line cache   |
// |               with tree PLRU. CACHE_PERF_EN adds hit/miss/wb counters.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module cache_nway
    import cache_pkg::*;
#(
    parameter int WAYS   = 2,
    parameter int SETS   = 8,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_cyc,
    input  logic              s_stb,
    input  logic              s_we,
    input  logic [ADDR_W-1:0] s_adr,
    input  logic [15:0]       s_sel,
    input  logic [127:0]      s_dat_m,
    output logic [127:0]      s_dat_s,
    output logic              s_ack,
    output logic              write_hit,
    output logic              m_cyc,
    output logic              m_stb,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_adr,
    output logic [15:0]       m_sel,
    output logic [127:0]      m_dat_m,
    input  logic [127:0]      m_dat_s,
    input  logic              m_ack
`ifdef CACHE_PERF_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
    output logic [31:0]       wb_count
`endif
);

    localparam int c_IDX_W = $clog2(SETS);
    localparam int c_TAG_W = ADDR_W - c_IDX_W;
    localparam int c_WAY_W = $clog2(WAYS);

    cache_line_t        r_data  [SETS][WAYS];
    logic [c_TAG_W-1:0] r_tag   [SETS][WAYS];
    logic [WAYS-1:0]    r_valid [SETS];
    logic [WAYS-1:0]    r_dirty [SETS];
    logic [WAYS-2:0]    r_plru  [SETS];

    state_t             r_state, w_state_next;
    logic [ADDR_W-1:0]  r_adr;
    logic               r_we;
    line_sel_t          r_sel;
    cache_line_t        r_wdat;
    logic [c_WAY_W-1:0] r_victim;
    logic               r_replay;

    logic               r_s_ack, r_write_hit, r_m_cyc, r_m_we;
    cache_line_t        r_s_dat, r_m_dat;
    logic [ADDR_W-1:0]  r_m_adr;

    logic [c_IDX_W-1:0] w_idx;
    logic [c_TAG_W-1:0] w_tag;
    logic [WAYS-1:0]    w_hit_vec;
    logic               w_hit, w_any_inv, w_vic_dirty;
    logic [c_WAY_W-1:0] w_hit_way, w_inv_way, w_plru_victim, w_victim;
    logic [WAYS-2:0]    w_plru_next;
    cache_line_t        w_hit_line, w_merged;

    assign w_idx = r_adr[c_IDX_W-1:0];
    assign w_tag = r_adr[ADDR_W-1:c_IDX_W];

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        assign w_hit_vec[g] = r_valid[w_idx][g] && (r_tag[w_idx][g] == w_tag);
    end

    always_comb begin
        w_hit_way = '0;
        w_inv_way = '0;
        for (int w = WAYS-1; w >= 0; w--) begin
            if (w_hit_vec[w])        w_hit_way = c_WAY_W'(w);
            if (!r_valid[w_idx][w])  w_inv_way = c_WAY_W'(w);
        end
    end

    cache_plru #(.WAYS(WAYS)) u_plru (
        .i_tree    (r_plru[w_idx]),
        .i_hit_way (w_hit_way),
        .o_tree    (w_plru_next),
        .o_victim  (w_plru_victim)
    );

    assign w_hit       = |w_hit_vec;
    assign w_any_inv   = ~&r_valid[w_idx];
    assign w_victim    = w_any_inv ? w_inv_way : w_plru_victim;
    assign w_vic_dirty = r_valid[w_idx][w_victim] & r_dirty[w_idx][w_victim];
    assign w_hit_line  = r_data[w_idx][w_hit_way];
    assign w_merged    = merge_line(w_hit_line, r_wdat, r_sel);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (s_cyc && s_stb && !r_s_ack) w_state_next = LOOKUP;
            LOOKUP:    if (w_hit)            w_state_next = IDLE;
                       else if (w_vic_dirty) w_state_next = WRITEBACK;
                       else                  w_state_next = ALLOCATE;
            WRITEBACK: if (m_ack)            w_state_next = ALLOCATE;
            ALLOCATE:  if (r_m_cyc && m_ack) w_state_next = LOOKUP;
            default:                         w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s_ack     <= 1'b0;
            r_write_hit <= 1'b0;
            r_s_dat     <= '0;
            r_m_cyc     <= 1'b0;
            r_m_we      <= 1'b0;
            r_m_adr     <= '0;
            r_m_dat     <= '0;
            r_adr       <= '0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_wdat      <= '0;
            r_victim    <= '0;
            r_replay    <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else begin
            r_s_ack     <= 1'b0;
            r_write_hit <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (s_cyc && s_stb && !r_s_ack) begin
                        r_adr  <= s_adr;
                        r_we   <= s_we;
                        r_sel  <= s_sel;
                        r_wdat <= s_dat_m;
                    end
                end
                LOOKUP: begin
                    if (w_hit) begin
                        r_s_ack       <= 1'b1;
                        r_s_dat       <= r_we ? w_merged : w_hit_line;
                        r_plru[w_idx] <= w_plru_next;
                        r_replay      <= 1'b0;
                        if (r_we) begin
                            r_dirty[w_idx][w_hit_way] <= 1'b1;
                            r_write_hit               <= !r_replay;
                        end
                    end else begin
                        r_victim <= w_victim;
                        r_m_cyc  <= 1'b1;
                        if (w_vic_dirty) begin
                            r_m_we  <= 1'b1;
                            r_m_adr <= {r_tag[w_idx][w_victim], w_idx};
                            r_m_dat <= r_data[w_idx][w_victim];
                        end else begin
                            r_m_we  <= 1'b0;
                            r_m_adr <= r_adr;
                        end
                    end
                end
                WRITEBACK: begin
                    if (m_ack) begin
                        r_m_cyc <= 1'b0;
                        r_m_we  <= 1'b0;
                    end
                end
                ALLOCATE: begin
                    // After a write-back the bus idles one cycle before the fill starts.
                    if (!r_m_cyc) begin
                        r_m_cyc <= 1'b1;
                        r_m_we  <= 1'b0;
                        r_m_adr <= r_adr;
                    end else if (m_ack) begin
                        r_m_cyc                  <= 1'b0;
                        r_valid[w_idx][r_victim] <= 1'b1;
                        r_dirty[w_idx][r_victim] <= 1'b0;
                        r_replay                 <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (r_state == LOOKUP && w_hit && r_we) begin
                r_data[w_idx][w_hit_way] <= w_merged;
            end
            if (r_state == ALLOCATE && r_m_cyc && m_ack) begin
                r_data[w_idx][r_victim] <= m_dat_s;
                r_tag[w_idx][r_victim]  <= w_tag;
            end
        end
    end

    assign s_ack     = r_s_ack;
    assign s_dat_s   = r_s_dat;
    assign write_hit = r_write_hit;
    assign m_cyc     = r_m_cyc;
    assign m_stb     = r_m_cyc;
    assign m_we      = r_m_we;
    assign m_adr     = r_m_adr;
    assign m_sel     = {16{r_m_cyc}};
    assign m_dat_m   = r_m_dat;

`ifdef CACHE_PERF_EN
    logic [31:0] r_hit_cnt, r_miss_cnt, r_wb_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_wb_cnt   <= '0;
        end else begin
            if (r_state == LOOKUP && w_hit && !r_replay && r_hit_cnt != '1)
                r_hit_cnt <= r_hit_cnt + 32'd1;
            if (r_state == LOOKUP && !w_hit && r_miss_cnt != '1)
                r_miss_cnt <= r_miss_cnt + 32'd1;
            if (r_state == WRITEBACK && m_ack && r_wb_cnt != '1)
                r_wb_cnt <= r_wb_cnt + 32'd1;
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
    assign wb_count   = r_wb_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_nway.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cache_nway                                                |
// | Description : Scoreboard bench for cache_nway (WAYS=2, SETS=8, ADDR_W=12). |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_cache_nway;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_cyc, s_stb, s_we;
    logic [11:0]  s_adr;
    logic [15:0]  s_sel;
    logic [127:0] s_dat_m, s_dat_s;
    logic         s_ack, write_hit;
    logic         m_cyc, m_stb, m_we;
    logic [11:0]  m_adr;
    logic [15:0]  m_sel;
    logic [127:0] m_dat_m, m_dat_s;
    logic         m_ack;
`ifdef CACHE_PERF_EN
    logic [31:0]  hit_count, miss_count, wb_count;
`endif

    cache_nway #(.WAYS(2), .SETS(8), .ADDR_W(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
        .s_dat_m(s_dat_m), .s_dat_s(s_dat_s), .s_ack(s_ack), .write_hit(write_hit),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_sel(m_sel),
        .m_dat_m(m_dat_m), .m_dat_s(m_dat_s), .m_ack(m_ack)
`ifdef CACHE_PERF_EN
        , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic         we;
        logic [127:0] dat;
        logic         wh;
        int           lat;
        int           issue;
    } sb_t;

    typedef struct {
        logic         we;
        logic [11:0]  adr;
        logic [127:0] dat;
    } bus_t;

    sb_t  sb_q[$];
    bus_t bus_q[$];
    int   checks = 0;
    int   errors = 0;
    int   mem_wait = 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] line_of(input logic [11:0] a);
        return {16{8'hA5}} ^ {a, 116'd0};
    endfunction

    // Memory responder: mem_wait wait states, then a one-cycle m_ack.
    initial begin : p_mem
        int   wcnt;
        logic seen;
        bus_t b;
        m_ack = 1'b0;
        m_dat_s = '0;
        wcnt = 0;
        seen = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (m_ack) begin
                m_ack = 1'b0;
                wcnt = 0;
                seen = 1'b0;
            end else if (!(m_cyc && m_stb)) begin
                wcnt = 0;
                seen = 1'b0;
            end else begin
                if (!seen && bus_q.size() != 0) begin
                    chk("bus_first_adr", 128'(m_adr), 128'(bus_q[0].adr));
                end
                seen = 1'b1;
                if (wcnt < mem_wait) begin
                    wcnt++;
                end else begin
                    m_ack = 1'b1;
                    if (bus_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL bus_unexpected: got we=%0b adr=%h, expected no transaction", m_we, m_adr);
                    end else begin
                        b = bus_q.pop_front();
                        chk("bus_we", 128'(m_we), 128'(b.we));
                        chk("bus_adr", 128'(m_adr), 128'(b.adr));
                        chk("bus_sel", 128'(m_sel), 128'(16'hFFFF));
                        if (b.we) chk("bus_wdat", m_dat_m, b.dat);
                    end
                    if (!m_we) m_dat_s = line_of(m_adr);
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every s_ack.
    initial begin : p_mon
        sb_t e;
        forever begin
            @(negedge clk);
            if (write_hit && !s_ack) begin
                checks++;
                errors++;
                $display("FAIL write_hit_stray: got 1 expected 0 outside s_ack");
            end
            if (s_ack) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_unexpected: got s_ack=1 expected 0");
                end else begin
                    e = sb_q.pop_front();
                    if (!e.we) chk("read_data", s_dat_s, e.dat);
                    chk("write_hit", 128'(write_hit), 128'(e.wh));
                    if (e.lat >= 0) chk("ack_latency", 128'(cyc - e.issue), 128'(e.lat));
                end
            end
        end
    end

    task automatic exp_bus(input logic we, input logic [11:0] adr, input logic [127:0] dat);
        bus_t b;
        b.we = we;
        b.adr = adr;
        b.dat = dat;
        bus_q.push_back(b);
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic do_req(input logic we, input logic [11:0] adr, input logic [15:0] sel,
                          input logic [127:0] wdat, input logic [127:0] exp_dat,
                          input logic exp_wh, input int exp_lat);
        sb_t  e;
        logic got;
        e.we = we;
        e.dat = exp_dat;
        e.wh = exp_wh;
        e.lat = exp_lat;
        e.issue = cyc;
        sb_q.push_back(e);
        s_we = we; s_adr = adr; s_sel = sel; s_dat_m = wdat;
        s_cyc = 1'b1; s_stb = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (s_ack) got = 1'b1;
        end
        s_cyc = 1'b0; s_stb = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: adr=%h got no s_ack expected s_ack", adr);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic bus_done(input string name);
        chk(name, 128'(bus_q.size()), 128'd0);
    endtask

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : p_main
        logic [127:0] l, d, m;
        logic         got;
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        s_adr = '0; s_sel = '0; s_dat_m = '0;
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_s_ack",     128'(s_ack),     128'd0);
        chk("rst_write_hit", 128'(write_hit), 128'd0);
        chk("rst_m_cyc",     128'(m_cyc),     128'd0);
        chk("rst_m_stb",     128'(m_stb),     128'd0);
        chk("rst_m_we",      128'(m_we),      128'd0);
        chk("rst_m_adr",     128'(m_adr),     128'd0);
        chk("rst_s_dat_s",   s_dat_s,         128'd0);
        chk("rst_m_dat_m",   m_dat_m,         128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Cold read with 3 wait states, then a hit on the same line.
        mem_wait = 3;
        exp_bus(1'b0, 12'h010, '0);
        do_req(1'b0, 12'h010, 16'h0000, '0, line_of(12'h010), 1'b0, -1);
        do_req(1'b0, 12'h010, 16'h0000, '0, line_of(12'h010), 1'b0, 2);

        // Write hit on bytes 1:0, then read back the merged line.
        d = {{14{8'h77}}, 16'hBEEF};
        do_req(1'b1, 12'h010, 16'h0003, d, '0, 1'b1, 2);
        l = line_of(12'h010);
        l[15:0] = 16'hBEEF;
        do_req(1'b0, 12'h010, 16'h0000, '0, l, 1'b0, 2);
        bus_done("hit_bus_idle");

        // Dirty eviction in set 0.
        do_reset();
        mem_wait = 1;
        d = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        exp_bus(1'b0, 12'h000, '0);
        do_req(1'b1, 12'h000, 16'h00F0, d, '0, 1'b0, -1);
        exp_bus(1'b0, 12'h008, '0);
        do_req(1'b0, 12'h008, 16'h0000, '0, line_of(12'h008), 1'b0, -1);
        m = line_of(12'h000);
        m[63:32] = 32'hFEDC_BA98;
        exp_bus(1'b1, 12'h000, m);
        exp_bus(1'b0, 12'h010, '0);
        do_req(1'b0, 12'h010, 16'h0000, '0, line_of(12'h010), 1'b0, -1);
`ifdef CACHE_PERF_EN
        chk("perf_miss", 128'(miss_count), 128'd3);
        chk("perf_wb",   128'(wb_count),   128'd1);
        chk("perf_hit",  128'(hit_count),  128'd0);
`endif
        do_req(1'b0, 12'h008, 16'h0000, '0, line_of(12'h008), 1'b0, 2);
        bus_done("dirty_evict_bus");

        // Clean eviction, zero wait states, PLRU victim choice.
        do_reset();
        mem_wait = 0;
        exp_bus(1'b0, 12'h000, '0);
        do_req(1'b0, 12'h000, 16'h0000, '0, line_of(12'h000), 1'b0, -1);
        exp_bus(1'b0, 12'h008, '0);
        do_req(1'b0, 12'h008, 16'h0000, '0, line_of(12'h008), 1'b0, -1);
        exp_bus(1'b0, 12'h010, '0);
        do_req(1'b0, 12'h010, 16'h0000, '0, line_of(12'h010), 1'b0, -1);
        do_req(1'b0, 12'h008, 16'h0000, '0, line_of(12'h008), 1'b0, 2);
        exp_bus(1'b0, 12'h000, '0);
        do_req(1'b0, 12'h000, 16'h0000, '0, line_of(12'h000), 1'b0, -1);
        do_req(1'b0, 12'h008, 16'h0000, '0, line_of(12'h008), 1'b0, 2);
        bus_done("clean_evict_bus");

        // Reset during ALLOCATE abandons the fill.
        mem_wait = 1000;
        s_we = 1'b0; s_adr = 12'h018; s_sel = '0; s_dat_m = '0;
        s_cyc = 1'b1; s_stb = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (m_cyc) got = 1'b1;
        end
        chk("abort_alloc_seen", 128'(got),   128'd1);
        chk("abort_alloc_adr",  128'(m_adr), 128'(12'h018));
        chk("abort_alloc_we",   128'(m_we),  128'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        s_cyc = 1'b0; s_stb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_m_cyc", 128'(m_cyc), 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_wait = 1;
        exp_bus(1'b0, 12'h018, '0);
        do_req(1'b0, 12'h018, 16'h0000, '0, line_of(12'h018), 1'b0, -1);
        exp_bus(1'b0, 12'h008, '0);
        do_req(1'b0, 12'h008, 16'h0000, '0, line_of(12'h008), 1'b0, -1);
        bus_done("abort_bus");

        repeat (3) @(posedge clk);
        chk("sb_drained", 128'(sb_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
